// File: rtl/bist_test_sequencer.sv
// bist_test_sequencer: scan-BIST controller for the systolic array.
// Steps through the stuck-at patterns and then the transition-delay
// launch/capture pairs, handshaking each pattern with the scan/compare
// datapath. It ORs every per-PE mismatch into a fault map and finally
// writes that map row by row into the faulty-PE storage, together with
// the row/column fault vectors derived from it.
//
// Optional feature macro: BIST_EARLY_ABORT_EN
//   defined   - the first failing pattern ends the run and goes straight
//               to the storage write (a failing TD launch skips its capture)
//   undefined - every selected pattern is always applied
module bist_test_sequencer #(
    parameter int unsigned SYSTOLIC_SIZE          = 8,
    parameter int unsigned ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
    parameter int unsigned SA_TEST_PATTERN_DEPTH  = 12,
    parameter int unsigned TD_TEST_PATTERN_DEPTH  = 18,
    parameter int unsigned MAX_PATTERN_ADDR_WIDTH =
        $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
               SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH),
    parameter int unsigned ROW_THRESH             = 2,
    parameter int unsigned COL_THRESH             = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [1:0]                               mode,
    output logic                                     test_type,
    output logic                                     TD_answer_choose,
    output logic [MAX_PATTERN_ADDR_WIDTH-1:0]        pattern_counter,
    output logic                                     apply_req,
    input  logic                                     apply_ack,
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0]   fail_flat,
    output logic                                     detection_en,
    output logic [ADDR_WIDTH-1:0]                    detection_addr,
    output logic [SYSTOLIC_SIZE-1:0]                 single_pe_detection,
    output logic [SYSTOLIC_SIZE-1:0]                 row_fault_detection,
    output logic [SYSTOLIC_SIZE-1:0]                 column_fault_detection,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     any_fault
);

    localparam logic [MAX_PATTERN_ADDR_WIDTH-1:0] SA_LAST =
        MAX_PATTERN_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [MAX_PATTERN_ADDR_WIDTH-1:0] TD_LAST =
        MAX_PATTERN_ADDR_WIDTH'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StAdvance,
        StStore,
        StDone
    } state_e;

    state_e                                              r_state;
    logic                                                r_run_td;     // TD follows SA (mode 11)
    logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0]         r_fmap;       // [row][col]
    logic                                                r_test_type;
    logic                                                r_choose;
    logic [MAX_PATTERN_ADDR_WIDTH-1:0]                   r_pc;
    logic                                                r_req;
    logic                                                r_det_en;
    logic [ADDR_WIDTH-1:0]                               r_addr;
    logic [SYSTOLIC_SIZE-1:0]                            r_row_flags;
    logic [SYSTOLIC_SIZE-1:0]                            r_col_flags;
    logic                                                r_busy;
    logic                                                r_done;
    logic                                                r_any_fault;

    logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0]         w_fail_map;
    logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0]         w_map_upd;
    logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0]         w_map_src;
    logic [SYSTOLIC_SIZE-1:0]                            w_row_flags;
    logic [SYSTOLIC_SIZE-1:0]                            w_col_flags;
    logic                                                w_abort;

    assign w_fail_map = fail_flat;
    assign w_map_upd  = r_fmap | w_fail_map;

`ifdef BIST_EARLY_ABORT_EN
    assign w_abort = |fail_flat;
`else
    assign w_abort = 1'b0;
`endif

    // Map the flags are derived from: an early abort enters STORE straight from
    // APPLY, so the failing pattern's mismatches must be included on that edge.
    always_comb begin
        w_map_src = (r_state == StApply) ? w_map_upd : r_fmap;
    end

    // Row/column popcount against the thresholds.
    always_comb begin
        int unsigned v_cnt;
        w_row_flags = '0;
        w_col_flags = '0;
        for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
            v_cnt = 0;
            for (int unsigned c = 0; c < SYSTOLIC_SIZE; c++) begin
                v_cnt = v_cnt + 32'(w_map_src[r][c]);
            end
            w_row_flags[r] = (v_cnt >= ROW_THRESH);
        end
        for (int unsigned c = 0; c < SYSTOLIC_SIZE; c++) begin
            v_cnt = 0;
            for (int unsigned r = 0; r < SYSTOLIC_SIZE; r++) begin
                v_cnt = v_cnt + 32'(w_map_src[r][c]);
            end
            w_col_flags[c] = (v_cnt >= COL_THRESH);
        end
    end

    // Sequencer FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_run_td    <= 1'b0;
            r_fmap      <= '0;
            r_test_type <= 1'b0;
            r_choose    <= 1'b0;
            r_pc        <= '0;
            r_req       <= 1'b0;
            r_det_en    <= 1'b0;
            r_addr      <= '0;
            r_row_flags <= '0;
            r_col_flags <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_any_fault <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_run_td    <= mode[1];
                        r_fmap      <= '0;
                        r_any_fault <= 1'b0;
                        r_row_flags <= '0;
                        r_col_flags <= '0;
                        r_busy      <= 1'b1;
                        r_pc        <= '0;
                        r_choose    <= 1'b0;
                        if (mode == 2'b00) begin
                            r_state <= StDone;
                        end else begin
                            r_state     <= StApply;
                            r_req       <= 1'b1;
                            r_test_type <= (mode == 2'b10);
                        end
                    end
                end
                StApply: begin
                    if (apply_ack) begin
                        r_fmap      <= w_map_upd;
                        r_any_fault <= |w_map_upd;
                        r_req       <= 1'b0;
                        if (w_abort) begin
                            r_state     <= StStore;
                            r_det_en    <= 1'b1;
                            r_addr      <= '0;
                            r_row_flags <= w_row_flags;
                            r_col_flags <= w_col_flags;
                        end else begin
                            r_state <= StAdvance;
                        end
                    end
                end
                StAdvance: begin
                    if (!r_test_type && (r_pc != SA_LAST)) begin
                        r_pc    <= r_pc + 1'b1;
                        r_req   <= 1'b1;
                        r_state <= StApply;
                    end else if (!r_test_type && r_run_td) begin
                        // SA finished, continue with TD pattern 0 launch
                        r_test_type <= 1'b1;
                        r_pc        <= '0;
                        r_choose    <= 1'b0;
                        r_req       <= 1'b1;
                        r_state     <= StApply;
                    end else if (r_test_type && !r_choose) begin
                        r_choose <= 1'b1;
                        r_req    <= 1'b1;
                        r_state  <= StApply;
                    end else if (r_test_type && (r_pc != TD_LAST)) begin
                        r_pc     <= r_pc + 1'b1;
                        r_choose <= 1'b0;
                        r_req    <= 1'b1;
                        r_state  <= StApply;
                    end else begin
                        r_state     <= StStore;
                        r_det_en    <= 1'b1;
                        r_addr      <= '0;
                        r_row_flags <= w_row_flags;
                        r_col_flags <= w_col_flags;
                    end
                end
                StStore: begin
                    if (r_addr == ADDR_LAST) begin
                        r_det_en <= 1'b0;
                        r_state  <= StDone;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                StDone: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_pc        <= '0;
                    r_test_type <= 1'b0;
                    r_choose    <= 1'b0;
                    r_addr      <= '0;
                    r_state     <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign test_type              = r_test_type;
    assign TD_answer_choose       = r_choose;
    assign pattern_counter        = r_pc;
    assign apply_req              = r_req;
    assign detection_en           = r_det_en;
    assign detection_addr         = r_addr;
    assign single_pe_detection    = r_det_en ? r_fmap[r_addr] : '0;
    assign row_fault_detection    = r_row_flags;
    assign column_fault_detection = r_col_flags;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign any_fault              = r_any_fault;

endmodule

// File: tb/tb_bist_test_sequencer.sv
// Bench for bist_test_sequencer: randomized handshake latencies and fault
// injection, checked every cycle against a pattern-list / fault-map model.
module tb_bist_test_sequencer;

    localparam int S    = 8;
    localparam int SA_D = 12;
    localparam int TD_D = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        apply_ack = 1'b0;
    logic [63:0] fail_flat = '0;

    logic        test_type, td_choose, apply_req, detection_en, busy, done, any_fault;
    logic [4:0]  pattern_counter;
    logic [2:0]  detection_addr;
    logic [7:0]  single_pe_detection, row_fault_detection, column_fault_detection;

    bist_test_sequencer dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .mode                   (mode),
        .test_type              (test_type),
        .TD_answer_choose       (td_choose),
        .pattern_counter        (pattern_counter),
        .apply_req              (apply_req),
        .apply_ack              (apply_ack),
        .fail_flat              (fail_flat),
        .detection_en           (detection_en),
        .detection_addr         (detection_addr),
        .single_pe_detection    (single_pe_detection),
        .row_fault_detection    (row_fault_detection),
        .column_fault_detection (column_fault_detection),
        .busy                   (busy),
        .done                   (done),
        .any_fault              (any_fault)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [4:0]  e_pc [64];
    logic        e_ty [64];
    logic        e_ch [64];
    int          exp_n, k, wr_i, req_cd, st_cd, dn_cd;
    logic [63:0] m_fmap;
    bit          m_busy, m_req, m_wr, m_any, m_armed, e_done, ab;

    // captured DUT storage writes
    int          dut_wr;
    logic [7:0]  cap_data [8];
    logic [7:0]  cap_row, cap_col;

    function automatic void build(input logic [1:0] m);
        exp_n = 0;
        if (m[0]) begin
            for (int i = 0; i < SA_D; i++) begin
                e_pc[exp_n] = 5'(i); e_ty[exp_n] = 1'b0; e_ch[exp_n] = 1'b0;
                exp_n = exp_n + 1;
            end
        end
        if (m[1]) begin
            for (int i = 0; i < TD_D; i++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    e_pc[exp_n] = 5'(i); e_ty[exp_n] = 1'b1; e_ch[exp_n] = ph[0];
                    exp_n = exp_n + 1;
                end
            end
        end
    endfunction

    function automatic logic [7:0] row_of(input logic [63:0] fm, input int r);
        return 8'(fm >> (r * S));
    endfunction

    function automatic logic [7:0] flags(input logic [63:0] fm, input bit by_col);
        logic [7:0] res;
        int cnt;
        res = '0;
        for (int a = 0; a < S; a++) begin
            cnt = 0;
            for (int b = 0; b < S; b++) begin
                cnt += int'((fm >> (by_col ? (b * S + a) : (a * S + b))) & 64'd1);
            end
            res[a] = (cnt >= 2);
        end
        return res;
    endfunction

    // Compare process: advances the model one cycle and checks all outputs.
    initial begin
        m_armed = 0; m_busy = 0; m_req = 0; m_wr = 0; m_any = 0; m_fmap = '0;
        req_cd = 0; st_cd = 0; dn_cd = 0; k = 0; exp_n = 0; wr_i = 0; dut_wr = 0;
        forever begin
            @(negedge clk);
            e_done = 0;
            if (req_cd > 0) begin req_cd--; if (req_cd == 0) m_req = 1; end
            if (st_cd > 0) begin st_cd--; if (st_cd == 0) begin m_wr = 1; wr_i = 0; end end
            if (dn_cd > 0) begin dn_cd--; if (dn_cd == 0) e_done = 1; end
            if (e_done) m_busy = 0;
            if (detection_en === 1'b1) begin
                dut_wr = dut_wr + 1;
                cap_data[detection_addr] = single_pe_detection;
                cap_row = row_fault_detection;
                cap_col = column_fault_detection;
            end
            if (m_armed) begin
                chk("busy", 64'(busy), 64'(m_busy));
                chk("done", 64'(done), 64'(e_done));
                chk("apply_req", 64'(apply_req), 64'(m_req));
                chk("detection_en", 64'(detection_en), 64'(m_wr));
                chk("any_fault", 64'(any_fault), 64'(m_any));
                if (m_req && k < 64)
                    chk("pattern{cnt,type,choose}", 64'({pattern_counter, test_type, td_choose}),
                        64'({e_pc[k], e_ty[k], e_ch[k]}));
                if (!m_busy)
                    chk("idle_pattern", 64'({pattern_counter, test_type, td_choose}), 64'd0);
                if (m_wr) begin
                    chk("detection_addr", 64'(detection_addr), 64'(wr_i));
                    chk("single_pe_detection", 64'(single_pe_detection), 64'(row_of(m_fmap, wr_i)));
                    chk("row_fault_detection", 64'(row_fault_detection), 64'(flags(m_fmap, 1'b0)));
                    chk("column_fault_detection", 64'(column_fault_detection),
                        64'(flags(m_fmap, 1'b1)));
                    wr_i = wr_i + 1;
                    if (wr_i == S) begin m_wr = 0; dn_cd = 2; end
                end
            end
            if (rst) begin
                m_armed = 1; m_busy = 0; m_req = 0; m_wr = 0; m_any = 0; m_fmap = '0;
                req_cd = 0; st_cd = 0; dn_cd = 0; k = 0; exp_n = 0;
            end else if (m_armed) begin
                if (!m_busy && start) begin
                    m_busy = 1; m_fmap = '0; m_any = 0; k = 0;
                    build(mode);
                    if (mode == 2'b00) dn_cd = 2;
                    else req_cd = 1;
                end else if (m_req && apply_ack) begin
                    m_fmap = m_fmap | fail_flat;
                    m_any = (m_fmap != 0);
                    k = k + 1;
                    m_req = 0;
                    ab = 0;
`ifdef BIST_EARLY_ABORT_EN
                    ab = (fail_flat != 0);
`endif
                    if (ab) st_cd = 1;
                    else if (k >= exp_n) st_cd = 2;
                    else req_cd = 2;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] fail_tab [64];
    int          n_acks, t_start, t_done;

    task automatic clear_tab();
        for (int i = 0; i < 64; i++) fail_tab[i] = '0;
    endtask

    task automatic run(input logic [1:0] m, input int lat_lo, input int lat_hi,
                       input bit noise, input int rst_at);
        int w;
        bit pend;
        bit seen;
        n_acks = 0; dut_wr = 0; pend = 0; seen = 0; w = 0;
        for (int i = 0; i < 8; i++) cap_data[i] = '0;
        cap_row = '0; cap_col = '0;
        @(posedge clk); #1;
        mode = m; start = 1'b1; apply_ack = 1'b0; fail_flat = '0; t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin seen = 1; t_done = cyc; break; end
            apply_ack = 1'b0;
            fail_flat = '0;
            start = noise && busy && ($urandom_range(5, 0) == 0);
            if (noise) mode = 2'($urandom);
            if (apply_req) begin
                if (rst_at >= 0 && n_acks == rst_at) begin
                    rst = 1'b1; start = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
                if (!pend) begin pend = 1; w = $urandom_range(lat_hi, lat_lo); end
                if (w == 0) begin
                    apply_ack = 1'b1;
                    fail_flat = (n_acks < 64) ? fail_tab[n_acks] : '0;
                    n_acks = n_acks + 1;
                    pend = 0;
                end else begin
                    w = w - 1;
                end
            end
            @(posedge clk); #1;
        end
        apply_ack = 1'b0; fail_flat = '0; start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        clear_tab();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // SA only, fixed 2-cycle ack latency, no faults
        clear_tab();
        run(2'b01, 2, 2, 0, -1);
        chk("t1_acks", 64'(n_acks), 64'd12);
        chk("t1_writes", 64'(dut_wr), 64'd8);
        chk("t1_data_or", 64'(cap_data[0] | cap_data[3] | cap_data[7]), 64'd0);
        chk("t1_any_fault", 64'(any_fault), 64'd0);

        // TD only, random latency, start/mode noise while busy
        clear_tab();
        run(2'b10, 0, 3, 1, -1);
        chk("t2_acks", 64'(n_acks), 64'd36);

        // SA+TD: PE(3,5) at SA 4, PE(3,6) at TD 7 capture (ack index 12+15)
        clear_tab();
        fail_tab[4]  = 64'd1 << 29;
        fail_tab[27] = 64'd1 << 30;
        run(2'b11, 0, 2, 1, -1);
        chk("t3_acks", 64'(n_acks), 64'd48);
        chk("t3_row3", 64'(cap_data[3]), 64'h60);
        chk("t3_row_vec", 64'(cap_row), 64'h08);
        chk("t3_col_vec", 64'(cap_col), 64'h00);
        chk("t3_any_fault", 64'(any_fault), 64'd1);

        // column 2 hit in rows 0, 4, 6 on different patterns
        clear_tab();
        fail_tab[1] = 64'd1 << 2;
        fail_tab[5] = 64'd1 << 34;
        fail_tab[9] = 64'd1 << 50;
        run(2'b01, 1, 3, 0, -1);
        chk("t4_col_vec", 64'(cap_col), 64'h04);
        chk("t4_row_vec", 64'(cap_row), 64'h00);
        chk("t4_row4", 64'(cap_data[4]), 64'h04);

        // reset during TD pattern 9 launch (ack index 18)
        clear_tab();
        fail_tab[3] = 64'd1 << 7;
        run(2'b10, 0, 2, 0, 18);
        chk("t5_busy_after_rst", 64'(busy), 64'd0);
        chk("t5_any_after_rst", 64'(any_fault), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_no_writes", 64'(dut_wr), 64'd0);
        // acks while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            apply_ack = 1'b1; fail_flat = '1;
            @(posedge clk); #1;
        end
        apply_ack = 1'b0; fail_flat = '0;
        @(posedge clk); #1;
        chk("t5_idle_ack_any", 64'(any_fault), 64'd0);
        clear_tab();
        run(2'b01, 0, 1, 0, -1);
        chk("t5_rerun_acks", 64'(n_acks), 64'd12);

        // mode 00: done two cycles after start, nothing written
        run(2'b00, 0, 0, 1, -1);
        chk("t6_done_latency", 64'(t_done - t_start), 64'd2);
        chk("t6_writes", 64'(dut_wr), 64'd0);
        chk("t6_acks", 64'(n_acks), 64'd0);

`ifdef BIST_EARLY_ABORT_EN
        clear_tab();
        fail_tab[2] = 64'd1 << 9;
        run(2'b01, 1, 1, 0, -1);
        chk("t7_abort_acks", 64'(n_acks), 64'd3);
        chk("t7_row1", 64'(cap_data[1]), 64'h02);
`endif

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++)
                fail_tab[i] = ($urandom_range(5, 0) == 0) ? (64'd1 << $urandom_range(63, 0)) : '0;
            run(2'($urandom_range(3, 0)), 0, 3, 1, -1);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
